// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle controller:
// opcodes, FSM states, PC source selects and opcode classes.
package kgp_ctrl_pkg;

    localparam logic [5:0] OpAluRR      = 6'h00;
    localparam logic [5:0] OpAluImm     = 6'h01;
    localparam logic [5:0] OpLoad       = 6'h02;
    localparam logic [5:0] OpStore      = 6'h03;
    localparam logic [5:0] OpBranch     = 6'h04;
    localparam logic [5:0] OpBranchCond = 6'h05;
    localparam logic [5:0] OpHalt       = 6'h3F;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StMem    = 3'd4;
    localparam logic [2:0] StWb     = 3'd5;
    localparam logic [2:0] StHalt   = 3'd6;

    localparam logic [1:0] PcPlus4 = 2'd0;
    localparam logic [1:0] PcOff26 = 2'd1;
    localparam logic [1:0] PcImm21 = 2'd2;

    typedef enum logic [2:0] {
        ClsAluRR,
        ClsAluImm,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsBranchCond,
        ClsHalt,
        ClsIllegal
    } opclass_e;

endpackage

// File: rtl/kgp_opclass_decode.sv
// Combinational opcode classifier: main opcode to instruction class,
// flagging any opcode outside the defined set as illegal.
module kgp_opclass_decode
    import kgp_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output opclass_e   opclass,
    output logic       illegal
);

    always_comb begin
        opclass = ClsIllegal;
        illegal = 1'b0;
        case (opcode)
            OpAluRR:      opclass = ClsAluRR;
            OpAluImm:     opclass = ClsAluImm;
            OpLoad:       opclass = ClsLoad;
            OpStore:      opclass = ClsStore;
            OpBranch:     opclass = ClsBranch;
            OpBranchCond: opclass = ClsBranchCond;
            OpHalt:       opclass = ClsHalt;
            default:      illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/kgp_multicycle_control.sv
// Multi-cycle KGP-RISC control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared memory port and counts retired instructions.
module kgp_multicycle_control
    import kgp_ctrl_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [5:0]          opcode,
    input  logic                branch_cond,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_sel,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                alu_src_imm,
    output logic                rf_we,
    output logic                wb_sel_mem,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    logic [2:0]          state_q, state_d;
    logic [RETIRE_W-1:0] retired_q;
    logic                illegal_q;
    logic                retire_inc;
    logic                illegal_set;
    opclass_e            opclass;
    logic                op_illegal;

    kgp_opclass_decode u_opclass_decode (
        .opcode  (opcode),
        .opclass (opclass),
        .illegal (op_illegal)
    );

    always_comb begin
        state_d     = state_q;
        retire_inc  = 1'b0;
        illegal_set = 1'b0;
        case (state_q)
            StIdle:   if (start) state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                if (opclass == ClsHalt) begin
                    state_d    = StHalt;
                    retire_inc = 1'b1;
                end else if (op_illegal) begin
                    state_d     = StHalt;
                    illegal_set = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (opclass)
                    ClsAluRR, ClsAluImm:     state_d = StWb;
                    ClsLoad, ClsStore:       state_d = StMem;
                    ClsBranch, ClsBranchCond: begin
                        state_d    = StFetch;
                        retire_inc = 1'b1;
                    end
                    // Opcode changed under us after decode; park safely.
                    default: begin
                        state_d     = StHalt;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    if (opclass == ClsStore) begin
                        state_d    = StFetch;
                        retire_inc = 1'b1;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                state_d    = StFetch;
                retire_inc = 1'b1;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PcPlus4;
        alu_src_imm  = 1'b0;
        rf_we        = 1'b0;
        wb_sel_mem   = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                ir_we        = mem_ready;
                pc_we        = mem_ready;
            end
            StExec: begin
                alu_src_imm = (opclass == ClsAluImm) || (opclass == ClsLoad) ||
                              (opclass == ClsStore);
                if (opclass == ClsBranch) begin
                    pc_we  = 1'b1;
                    pc_src = PcOff26;
                end else if (opclass == ClsBranchCond) begin
                    pc_we  = branch_cond;
                    pc_src = PcImm21;
                end
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = (opclass == ClsStore);
            end
            StWb: begin
                rf_we      = 1'b1;
                wb_sel_mem = (opclass == ClsLoad);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire_inc) retired_q <= retired_q + RETIRE_W'(1);
            if (illegal_set) illegal_q <= 1'b1;
        end
    end

    assign busy    = (state_q != StIdle) && (state_q != StHalt);
    assign halted  = (state_q == StHalt);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule
